axi_mem_arb: RTL
================

# axi_mem_arb

Two-master to one-slave AXI arbiter that lets the instruction fetch port and the LSU port of `nox` share a single `axi_mem` instance, such as a unified IRAM/DRAM. Read and write directions are arbitrated independently. Each grant is held until its transaction completes, so IDs are never rewritten and responses route back to the grant holder. The block sits between the `nox` masters and the memory slave in simulation and SoC tops.

## Interface
Parameters:
- `RR_INIT`, default 1: reset value of the round-robin "last granted" pointer for both directions. With 1, master 0 wins the first contention.

Ports (structs from `utils_pkg`):
- `clk`, in, 1: clock.
- `arst`, in, 1: reset. Asynchronous and active-high.
- `m_axi_mosi_i`, in, `s_axi_mosi_t [1:0]`: master requests. Index 0 is instruction, index 1 is LSU.
- `m_axi_miso_o`, out, `s_axi_miso_t [1:0]`: responses to the masters.
- `s_axi_mosi_o`, out, `s_axi_mosi_t`: request to the shared slave.
- `s_axi_miso_i`, in, `s_axi_miso_t`: response from the shared slave.
- `rd_gnt_o`, out, 2: one-hot read grant. 0 when idle.
- `wr_gnt_o`, out, 2: one-hot write grant. 0 when idle.

## Operation
- Read FSM states and transitions:
  - RD_IDLE to RD_ADDR when either `arvalid` is high. The winner is latched into `rd_gnt_o`.
  - RD_ADDR to RD_DATA on the slave AR handshake.
  - RD_DATA to RD_IDLE on the R handshake with `rlast` = 1.
- Write FSM states and transitions:
  - WR_IDLE to WR_XFER when either `awvalid` is high. The winner is latched into `wr_gnt_o`.
  - WR_XFER to WR_RESP once both the AW handshake and the W handshake with `wlast` are done, in either order. Done flags `aw_done` and `w_done` track this.
  - WR_RESP to WR_IDLE on the B handshake.
- Routing:
  - Only the granted master's AR/R (or AW/W/B) fields are forwarded.
  - The non-granted master sees `arready`/`rvalid` (or `awready`/`wready`/`bvalid`) = 0.
  - Slave-side valids are 0 in the IDLE states.
- AW handling:
  - AW is forwarded only while WR_XFER && !`aw_done`.
  - After `aw_done`, `awvalid` to the slave is 0.
- W handling:
  - W is forwarded only while WR_XFER && !`w_done`.
  - Data beats pass through combinationally and can complete before AW.
- Arbitration:
  - A single requester wins immediately.
  - On contention, the master not equal to the last-granted pointer wins. The pointer updates to the winner on every grant.
  - The read and write pointers are separate.
- Concurrency: a read grant to one master and a write grant to either master may be active at once. The slave must accept independent read and write channels.
- A master's request that arrives while the other master holds that direction waits. Its valid stays asserted per AXI rules, and it is granted in the cycle the FSM returns to IDLE.

## Timing
- Reset values:
  - Both FSMs are in IDLE.
  - `rd_gnt_o` and `wr_gnt_o` are 0.
  - All valid/ready outputs are 0.
  - Both pointers equal `RR_INIT`.
  - Done flags are 0.
- Arbitration latency is 1 cycle. The grant is registered at the edge where `arvalid` or `awvalid` is seen in IDLE, and forwarding starts the next cycle.
- Data path latency after grant is 0: valid, ready, data and `last` pass combinationally.
- Back-to-back use: after the R `rlast` or B handshake at edge N, the FSM is IDLE in cycle N+1. A new grant is registered at edge N+1, so there is 1 dead cycle per transaction.
- `arst` asserted mid-transaction clears the FSMs and grants immediately and forces every valid/ready low asynchronously. Masters and slave are reset by the same `arst`.
- Slave `rresp`/`bresp` pass through unchanged.

## Configuration
- `AXI_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, where master 1 (LSU) always wins contention. Pointers are not instantiated and `RR_INIT` is ignored.
  - Undefined: round-robin as described under Operation.

## Test plan
- Single read: master 0 `araddr`=0x8000_0000, `arlen`=0.
  - `rd_gnt_o`=2'b01 one cycle after `arvalid`.
  - R data routed to master 0 only; master 1 `rvalid` stays 0.
  - FSM returns to RD_IDLE after `rlast`.
- Read contention: both masters assert `arvalid` in the same cycle after reset (`RR_INIT`=1).
  - Master 0 is served first.
  - Master 1 is granted one cycle after master 0's `rlast`.
  - Repeating the contention alternates 01, 10, 01.
- Write with W before AW:
  - Stimulus: master 1 presents `wvalid`/`wlast` with `wdata`=0xDEAD_BEEF and `wstrb`=0xF; the slave delays `awready` by 3 cycles.
  - The W handshake completes first; state stays WR_XFER until the AW handshake, then WR_RESP.
  - `bvalid` reaches master 1 only.
- Concurrent directions: master 0 burst read (`arlen`=3) overlapped with a master 1 write.
  - `rd_gnt_o`=01 and `wr_gnt_o`=10 are simultaneously high.
  - 4 R beats reach master 0; the B response reaches master 1.
- Reset mid-burst: assert `arst` during the 2nd of 4 R beats.
  - Grants and all valids are 0 in the same cycle.
  - After release, a fresh read is granted with pointer = `RR_INIT`.
- Fixed priority, with `AXI_ARB_FIXED_PRIO_EN` defined: contention repeated 3 times results in master 1 winning each time.

Source files
------------

// File: rtl/axi_mem_arb.sv
// axi_mem_arb: two-master to one-slave AXI arbiter with independent read/write grants held per transaction.
// Define AXI_ARB_FIXED_PRIO_EN for fixed priority (LSU wins); otherwise round-robin from RR_INIT.
package utils_pkg;
    typedef struct packed {
        logic [7:0]  awid;
        logic [31:0] awaddr;
        logic [7:0]  awlen;
        logic [2:0]  awsize;
        logic [1:0]  awburst;
        logic        awvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wlast;
        logic        wvalid;
        logic        bready;
        logic [7:0]  arid;
        logic [31:0] araddr;
        logic [7:0]  arlen;
        logic [2:0]  arsize;
        logic [1:0]  arburst;
        logic        arvalid;
        logic        rready;
    } s_axi_mosi_t;

    typedef struct packed {
        logic        awready;
        logic        wready;
        logic [7:0]  bid;
        logic [1:0]  bresp;
        logic        bvalid;
        logic        arready;
        logic [7:0]  rid;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        rlast;
        logic        rvalid;
    } s_axi_miso_t;
endpackage

module axi_mem_arb
    import utils_pkg::*;
#(
    parameter bit RR_INIT = 1'b1
) (
    input  logic              clk,
    input  logic              arst,
    input  s_axi_mosi_t [1:0] m_axi_mosi_i,
    output s_axi_miso_t [1:0] m_axi_miso_o,
    output s_axi_mosi_t       s_axi_mosi_o,
    input  s_axi_miso_t       s_axi_miso_i,
    output logic [1:0]        rd_gnt_o,
    output logic [1:0]        wr_gnt_o
);
    typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_state_t;
    typedef enum logic [1:0] {WR_IDLE, WR_XFER, WR_RESP} wr_state_t;

    rd_state_t  rd_st;
    wr_state_t  wr_st;
    logic       aw_done, w_done;
    logic [1:0] ar_req, aw_req, rd_pick, wr_pick;
    logic       rd_idx, wr_idx, ar_hs, r_end, aw_hs, w_end, b_hs;

    assign ar_req = {m_axi_mosi_i[1].arvalid, m_axi_mosi_i[0].arvalid};
    assign aw_req = {m_axi_mosi_i[1].awvalid, m_axi_mosi_i[0].awvalid};
    assign rd_idx = rd_gnt_o[1];
    assign wr_idx = wr_gnt_o[1];

`ifdef AXI_ARB_FIXED_PRIO_EN
    assign rd_pick = ar_req[1] ? 2'b10 : ar_req;
    assign wr_pick = aw_req[1] ? 2'b10 : aw_req;
`else
    logic rd_ptr, wr_ptr;
    // on contention the master that was not granted last time wins
    assign rd_pick = &ar_req ? (rd_ptr ? 2'b01 : 2'b10) : ar_req;
    assign wr_pick = &aw_req ? (wr_ptr ? 2'b01 : 2'b10) : aw_req;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rd_ptr <= RR_INIT;
            wr_ptr <= RR_INIT;
        end else begin
            if (rd_st == RD_IDLE && |ar_req) rd_ptr <= rd_pick[1];
            if (wr_st == WR_IDLE && |aw_req) wr_ptr <= wr_pick[1];
        end
    end
`endif

    always_comb begin
        s_axi_mosi_o         = m_axi_mosi_i[wr_idx];
        s_axi_mosi_o.arid    = m_axi_mosi_i[rd_idx].arid;
        s_axi_mosi_o.araddr  = m_axi_mosi_i[rd_idx].araddr;
        s_axi_mosi_o.arlen   = m_axi_mosi_i[rd_idx].arlen;
        s_axi_mosi_o.arsize  = m_axi_mosi_i[rd_idx].arsize;
        s_axi_mosi_o.arburst = m_axi_mosi_i[rd_idx].arburst;
        s_axi_mosi_o.arvalid = rd_st == RD_ADDR && m_axi_mosi_i[rd_idx].arvalid;
        s_axi_mosi_o.rready  = rd_st == RD_DATA && m_axi_mosi_i[rd_idx].rready;
        s_axi_mosi_o.awvalid = wr_st == WR_XFER && !aw_done && m_axi_mosi_i[wr_idx].awvalid;
        s_axi_mosi_o.wvalid  = wr_st == WR_XFER && !w_done && m_axi_mosi_i[wr_idx].wvalid;
        s_axi_mosi_o.bready  = wr_st == WR_RESP && m_axi_mosi_i[wr_idx].bready;
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            m_axi_miso_o[i]         = s_axi_miso_i;
            m_axi_miso_o[i].arready = rd_gnt_o[i] && rd_st == RD_ADDR && s_axi_miso_i.arready;
            m_axi_miso_o[i].rvalid  = rd_gnt_o[i] && rd_st == RD_DATA && s_axi_miso_i.rvalid;
            m_axi_miso_o[i].awready = wr_gnt_o[i] && wr_st == WR_XFER && !aw_done && s_axi_miso_i.awready;
            m_axi_miso_o[i].wready  = wr_gnt_o[i] && wr_st == WR_XFER && !w_done && s_axi_miso_i.wready;
            m_axi_miso_o[i].bvalid  = wr_gnt_o[i] && wr_st == WR_RESP && s_axi_miso_i.bvalid;
        end
    end

    assign ar_hs = s_axi_mosi_o.arvalid && s_axi_miso_i.arready;
    assign r_end = s_axi_mosi_o.rready && s_axi_miso_i.rvalid && s_axi_miso_i.rlast;
    assign aw_hs = s_axi_mosi_o.awvalid && s_axi_miso_i.awready;
    assign w_end = s_axi_mosi_o.wvalid && s_axi_miso_i.wready && s_axi_mosi_o.wlast;
    assign b_hs  = s_axi_mosi_o.bready && s_axi_miso_i.bvalid;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rd_st    <= RD_IDLE;
            rd_gnt_o <= '0;
        end else begin
            case (rd_st)
                RD_IDLE: if (|ar_req) begin
                    rd_st    <= RD_ADDR;
                    rd_gnt_o <= rd_pick;
                end
                RD_ADDR: if (ar_hs) rd_st <= RD_DATA;
                RD_DATA: if (r_end) begin
                    rd_st    <= RD_IDLE;
                    rd_gnt_o <= '0;
                end
                default: rd_st <= RD_IDLE;
            endcase
        end
    end

    // AW and the last W beat may complete in either order
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_st    <= WR_IDLE;
            wr_gnt_o <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            case (wr_st)
                WR_IDLE: if (|aw_req) begin
                    wr_st    <= WR_XFER;
                    wr_gnt_o <= wr_pick;
                end
                WR_XFER: if ((aw_done || aw_hs) && (w_done || w_end)) begin
                    wr_st   <= WR_RESP;
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                end else begin
                    aw_done <= aw_done || aw_hs;
                    w_done  <= w_done || w_end;
                end
                WR_RESP: if (b_hs) begin
                    wr_st    <= WR_IDLE;
                    wr_gnt_o <= '0;
                end
                default: wr_st <= WR_IDLE;
            endcase
        end
    end
endmodule
